// File: rtl/alu_instr_sequencer.sv
// Control front-end for the ALU datapath: serial opcode loader, launch/wait FSM,
// and the held result register that feeds the BCD converter.
module alu_instr_sequencer #(
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        reset_all_i,
    input  logic        instr_load_en_i,
    input  logic        instruction_in_i,
    input  logic        reset_instr_i,
    input  logic [11:0] dp_result_i,
    input  logic        dp_done_i,
    output logic [3:0]  opcode_o,
    output logic        dp_start_o,
    output logic [11:0] result_o,
    output logic        result_valid_o,
    output logic        busy_o,
    output logic [2:0]  bits_loaded_o,
    output logic        timeout_err_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {LOAD, ISSUE, EXEC_1, EXEC_M, DONE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] load_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   load_prev_q;
    logic                   load_edge;
    logic                   data_bit;
    logic [3:0]             opcode_q, opcode_d;
    logic [2:0]             bits_q, bits_d;
    logic [11:0]            result_q, result_d;
    logic                   valid_q, valid_d;
    logic                   terr_q, terr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   is_multi;

    // Synchronizer and edge history are only cleared by the global reset.
    always_ff @(posedge clk_i) begin
        if (reset_all_i) begin
            load_sync_q <= '0;
            data_sync_q <= '0;
            load_prev_q <= 1'b0;
        end else begin
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], instr_load_en_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], instruction_in_i};
            load_prev_q <= load_sync_q[SYNC_STAGES-1];
        end
    end

    assign load_edge = load_sync_q[SYNC_STAGES-1] & ~load_prev_q;
    assign data_bit  = data_sync_q[SYNC_STAGES-1];
    assign is_multi  = (opcode_q == 4'b1010) || (opcode_q == 4'b1011) || (opcode_q == 4'b1100);

    always_ff @(posedge clk_i) begin
        if (reset_all_i) begin
            state_q  <= LOAD;
            opcode_q <= '0;
            bits_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            bits_q   <= bits_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        bits_d   = bits_q;
        result_d = result_q;
        valid_d  = valid_q;
        terr_d   = terr_q;
        cnt_d    = cnt_q;
        if (!reset_instr_i) begin
            state_d  = LOAD;
            opcode_d = '0;
            bits_d   = '0;
            result_d = '0;
            valid_d  = 1'b0;
            terr_d   = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (load_edge) begin
                        opcode_d[bits_q[1:0]] = data_bit;
                        bits_d = bits_q + 3'd1;
                        if (bits_q == 3'd3) state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_d   = '0;
                    state_d = is_multi ? EXEC_M : EXEC_1;
                end
                EXEC_1: begin
                    result_d = dp_result_i;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
                EXEC_M: begin
                    // A completion on the final allowed cycle takes precedence over the timeout.
                    if (dp_done_i) begin
                        result_d = dp_result_i;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        result_d = '0;
                        valid_d  = 1'b1;
                        terr_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = LOAD;
            endcase
        end
    end

    always_comb begin
        opcode_o       = opcode_q;
        bits_loaded_o  = bits_q;
        result_o       = result_q;
        result_valid_o = valid_q;
        timeout_err_o  = terr_q;
        dp_start_o     = (state_q == ISSUE) && reset_instr_i;
        busy_o         = (state_q == EXEC_1) || (state_q == EXEC_M);
    end
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomized self-checking bench for alu_instr_sequencer; expectations come from
// a behavioural model of opcode classes, done delays and the timeout rule.
module tb_alu_instr_sequencer;
    localparam int TIMEOUT     = 64;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        resetAll;
    logic        loadEn;
    logic        instrBit;
    logic        resetInstr;
    logic [11:0] dpResult;
    logic        dpDone;
    logic [3:0]  opcode;
    logic        dpStart;
    logic [11:0] result;
    logic        resultValid;
    logic        busy;
    logic [2:0]  bitsLoaded;
    logic        timeoutErr;

    int checks = 0;
    int errors = 0;

    alu_instr_sequencer #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i           (clk),
        .reset_all_i     (resetAll),
        .instr_load_en_i (loadEn),
        .instruction_in_i(instrBit),
        .reset_instr_i   (resetInstr),
        .dp_result_i     (dpResult),
        .dp_done_i       (dpDone),
        .opcode_o        (opcode),
        .dp_start_o      (dpStart),
        .result_o        (result),
        .result_valid_o  (resultValid),
        .busy_o          (busy),
        .bits_loaded_o   (bitsLoaded),
        .timeout_err_o   (timeoutErr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit isMultiOp(input logic [3:0] op);
        return (op == 4'hA) || (op == 4'hB) || (op == 4'hC);
    endfunction

    task automatic pressBit(input logic b, input int hold);
        instrBit = b;
        loadEn   = 1'b1;
        repeat (hold) @(negedge clk);
        loadEn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic clearInstr(input string tag);
        resetInstr = 1'b0;
        @(negedge clk);
        resetInstr = 1'b1;
        checks++;
        if ({opcode, bitsLoaded, result, resultValid, busy, dpStart, timeoutErr} !== '0) begin
            errors++;
            $display("[TB] FAIL %s_clear: opcode=%b bits=%0d result=%0d valid=%b busy=%b start=%b terr=%b, expected all 0",
                     tag, opcode, bitsLoaded, result, resultValid, busy, dpStart, timeoutErr);
        end
    endtask

    // Loads op LSB first and returns at the cycle dp_start is seen.
    task automatic startOp(input logic [3:0] op, output bit started);
        int waitCnt;
        logic [3:0] partial;
        started = 1'b0;
        for (int b = 0; b < 3; b++) begin
            pressBit(op[b], 4);
            partial = op & 4'((1 << (b + 1)) - 1);
            checks++;
            if (bitsLoaded !== 3'(b + 1) || opcode !== partial) begin
                errors++;
                $display("[TB] FAIL load_bit%0d: bits=%0d opcode=%b, expected bits=%0d opcode=%b",
                         b, bitsLoaded, opcode, b + 1, partial);
            end
        end
        instrBit = op[3];
        loadEn   = 1'b1;
        waitCnt  = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (dpStart !== 1'b1 && waitCnt < 20);
        loadEn = 1'b0;
        checks++;
        if (dpStart !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dp_start_seen: dp_start=%b after %0d cycles, expected 1", dpStart, waitCnt);
        end else begin
            started = 1'b1;
        end
        checks++;
        if (bitsLoaded !== 3'd4 || opcode !== op) begin
            errors++;
            $display("[TB] FAIL issue_opcode: bits=%0d opcode=%b, expected bits=4 opcode=%b", bitsLoaded, opcode, op);
        end
    endtask

    // doneDelay = cycle after dp_start on which dp_done is pulsed; 0 means never.
    task automatic runOp(input logic [3:0] op, input logic [11:0] res, input int doneDelay, input string tag);
        bit started;
        bit multi;
        bit expTerr;
        logic [11:0] expRes;
        int expBusy;
        int busyCount;
        int validAt;
        multi   = isMultiOp(op);
        expTerr = multi && (doneDelay < 1 || doneDelay > TIMEOUT);
        expRes  = expTerr ? 12'd0 : res;
        expBusy = !multi ? 1 : (expTerr ? TIMEOUT : doneDelay);
        dpResult  = res;
        busyCount = 0;
        validAt   = 0;
        startOp(op, started);
        if (started) begin
            for (int i = 1; i <= TIMEOUT + 8; i++) begin
                @(negedge clk);
                dpDone = 1'b0;
                if (i == 1) begin
                    checks++;
                    if (dpStart !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL %s_start_pulse: dp_start=%b one cycle later, expected 0", tag, dpStart);
                    end
                end
                if (resultValid === 1'b1) begin
                    validAt = i;
                    break;
                end
                if (busy === 1'b1) busyCount++;
                if (i == doneDelay) dpDone = 1'b1;
            end
            dpDone = 1'b0;
            checks++;
            if (validAt != expBusy + 1) begin
                errors++;
                $display("[TB] FAIL %s_latency: valid at cycle %0d after start, expected %0d", tag, validAt, expBusy + 1);
            end
            checks++;
            if (busyCount != expBusy) begin
                errors++;
                $display("[TB] FAIL %s_busy_cycles: got %0d, expected %0d", tag, busyCount, expBusy);
            end
            checks++;
            if (result !== expRes || timeoutErr !== expTerr) begin
                errors++;
                $display("[TB] FAIL %s_result: result=%0d terr=%b, expected result=%0d terr=%b",
                         tag, result, timeoutErr, expRes, expTerr);
            end
            checks++;
            if (busy !== 1'b0 || opcode !== op || bitsLoaded !== 3'd4) begin
                errors++;
                $display("[TB] FAIL %s_done_state: busy=%b opcode=%b bits=%0d, expected busy=0 opcode=%b bits=4",
                         tag, busy, opcode, bitsLoaded, op);
            end
        end
    endtask

    task automatic test_reset();
        resetAll   = 1'b1;
        resetInstr = 1'b0;
        loadEn     = 1'b0;
        instrBit   = 1'b0;
        dpDone     = 1'b0;
        dpResult   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({opcode, bitsLoaded, result, resultValid, busy, dpStart, timeoutErr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: opcode=%b bits=%0d result=%0d valid=%b busy=%b, expected all 0",
                     opcode, bitsLoaded, result, resultValid, busy);
        end
        resetAll   = 1'b0;
        resetInstr = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bitsLoaded, busy, dpStart, resultValid} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_release: bits=%0d busy=%b start=%b valid=%b, expected all 0",
                     bitsLoaded, busy, dpStart, resultValid);
        end
    endtask

    task automatic test_loader();
        runOp(4'b1000, 12'd38, 0, "add");
        clearInstr("add");
    endtask

    task automatic test_multi_cycle();
        runOp(4'b1011, 12'd357, 10, "mul");
        clearInstr("mul");
    endtask

    task automatic test_timeout();
        runOp(4'b1100, 12'($urandom), 0, "div_timeout");
        clearInstr("div_timeout");
        runOp(4'b1010, 12'($urandom), TIMEOUT, "mod_last_cycle");
        clearInstr("mod_last_cycle");
        runOp(4'b0000, 12'($urandom), 0, "xor");
        clearInstr("xor");
    endtask

    task automatic test_abort();
        bit started;
        dpResult = 12'd777;
        startOp(4'b1010, started);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_busy: busy=%b in EXEC_M, expected 1", busy);
        end
        clearInstr("abort");
        dpDone = 1'b1;
        @(negedge clk);
        dpDone = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({opcode, bitsLoaded, result, resultValid, busy, timeoutErr} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_late_done: result=%0d valid=%b busy=%b bits=%0d, expected all 0",
                     result, resultValid, busy, bitsLoaded);
        end
    endtask

    task automatic test_held_level();
        logic [11:0] r;
        r        = 12'($urandom);
        dpResult = r;
        instrBit = 1'b1;
        loadEn   = 1'b1;
        repeat (1000) @(negedge clk);
        checks++;
        if (bitsLoaded !== 3'd1 || opcode !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL held_level: bits=%0d opcode=%b, expected bits=1 opcode=0001", bitsLoaded, opcode);
        end
        loadEn = 1'b0;
        repeat (4) @(negedge clk);
        pressBit(1'b1, 4);
        pressBit(1'b0, 4);
        pressBit(1'b0, 4);
        checks++;
        if (resultValid !== 1'b1 || result !== r || opcode !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL held_op: valid=%b result=%0d opcode=%b, expected valid=1 result=%0d opcode=0011",
                     resultValid, result, opcode, r);
        end
        dpResult = ~r;
        for (int k = 0; k < 3; k++) pressBit(1'($urandom), 4);
        dpDone = 1'b1;
        @(negedge clk);
        dpDone = 1'b0;
        checks++;
        if (result !== r || opcode !== 4'b0011 || bitsLoaded !== 3'd4 || resultValid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_ignores_edges: result=%0d opcode=%b bits=%0d, expected result=%0d opcode=0011 bits=4",
                     result, opcode, bitsLoaded, r);
        end
        clearInstr("held");
    endtask

    task automatic test_discard_exec();
        bit started;
        logic [11:0] r;
        r        = 12'($urandom);
        dpResult = r;
        startOp(4'b1011, started);
        pressBit(1'b1, 4);
        checks++;
        if (busy !== 1'b1 || bitsLoaded !== 3'd4 || opcode !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL exec_edge_discard: busy=%b bits=%0d opcode=%b, expected busy=1 bits=4 opcode=1011",
                     busy, bitsLoaded, opcode);
        end
        dpDone = 1'b1;
        @(negedge clk);
        dpDone = 1'b0;
        checks++;
        if (resultValid !== 1'b1 || result !== r || timeoutErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL exec_done_capture: valid=%b result=%0d terr=%b, expected valid=1 result=%0d terr=0",
                     resultValid, result, timeoutErr, r);
        end
        clearInstr("exec_discard");
        repeat (6) @(negedge clk);
        checks++;
        if (bitsLoaded !== 3'd0) begin
            errors++;
            $display("[TB] FAIL not_queued: bits=%0d, expected 0", bitsLoaded);
        end
    endtask

    task automatic test_partial_clear();
        pressBit(1'b1, 4);
        pressBit(1'b1, 4);
        checks++;
        if (bitsLoaded !== 3'd2 || opcode !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL partial_two_bits: bits=%0d opcode=%b, expected bits=2 opcode=0011", bitsLoaded, opcode);
        end
        clearInstr("partial");
        resetInstr = 1'b0;
        pressBit(1'b1, 4);
        resetInstr = 1'b1;
        @(negedge clk);
        checks++;
        if (bitsLoaded !== 3'd0 || opcode !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL load_during_reset_instr: bits=%0d opcode=%b, expected bits=0 opcode=0000", bitsLoaded, opcode);
        end
        runOp(4'($urandom), 12'($urandom), 5, "after_partial");
        clearInstr("after_partial");
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        for (int n = 0; n < 8; n++) begin
            op = (n % 2 == 0) ? 4'($urandom_range(10, 12)) : 4'($urandom);
            runOp(op, 12'($urandom), $urandom_range(1, TIMEOUT + 3), "random");
            clearInstr("random");
        end
    endtask

    task automatic test_reset_priority();
        runOp(4'b0101, 12'd1234, 0, "pre_reset");
        resetAll   = 1'b1;
        resetInstr = 1'b0;
        @(negedge clk);
        checks++;
        if ({opcode, bitsLoaded, result, resultValid, busy, dpStart, timeoutErr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_priority: opcode=%b bits=%0d result=%0d valid=%b, expected all 0",
                     opcode, bitsLoaded, result, resultValid);
        end
        resetAll   = 1'b0;
        resetInstr = 1'b1;
        @(negedge clk);
        runOp(4'b0010, 12'd99, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_loader();
        test_multi_cycle();
        test_timeout();
        test_abort();
        test_held_level();
        test_discard_exec();
        test_partial_clear();
        test_back_to_back();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
Control front-end for alu_top's datapath. Collects the 4-bit opcode from the serial instruction_in line, one bit per instr_load_en press. Once the opcode is complete it launches the operation, then waits either one cycle or for a datapath done handshake. It holds the captured binary result for the downstream BCD converter until reset_instr or reset_all. It sits between the board switches/buttons and the ALU datapath.

Parameters:
TIMEOUT, 64, max cycles to wait for dp_done on a multi-cycle op before flagging an error
SYNC_STAGES, 2, flops in the instr_load_en / instruction_in synchronizer (minimum 2)

Ports:
clk  input  1  system clock
reset_all  input  1  synchronous, active-high; clears all state
instr_load_en  input  1  asynchronous load button, level; each rising edge loads one bit
instruction_in  input  1  asynchronous serial opcode bit, sampled on a load edge
reset_instr  input  1  synchronous, active-low; clears opcode and result, keeps no other state
dp_result  input  12  binary result from datapath
dp_done  input  1  datapath completion pulse for multi-cycle ops
opcode  output  4  assembled opcode, stable from dp_start until cleared
dp_start  output  1  one-cycle launch pulse to datapath
result  output  12  captured dp_result
result_valid  output  1  result holds a valid capture
busy  output  1  high in EXEC_1 and EXEC_M
bits_loaded  output  3  count of opcode bits received, 0..4
timeout_err  output  1  multi-cycle op exceeded TIMEOUT

Behaviour:
- Reset is synchronous. reset_all=1 has priority over everything. reset_instr=0 applies next; reset_all is the only reset that clears the synchronizers and the edge-detect history. Reset values: opcode=0, dp_start=0, result=0, result_valid=0, busy=0, bits_loaded=0, timeout_err=0, state=LOAD.
- instr_load_en and instruction_in each pass through SYNC_STAGES flops.
- Load edge = synced instr_load_en is 1 and was 0 on the previous cycle. No debounce; a held level produces exactly one edge.
- In LOAD, each load edge writes synced instruction_in to opcode[bits_loaded] (LSB first) and increments bits_loaded.
- The edge that brings bits_loaded to 4 moves the FSM to ISSUE.
- ISSUE: dp_start=1 for exactly one cycle.
  - If opcode is 1010 (MOD), 1011 (MUL) or 1100 (DIV), go to EXEC_M.
  - Otherwise go to EXEC_1.
- EXEC_1 (one cycle): capture dp_result into result, set result_valid, go to DONE.
  - Latency for a single-cycle op: result_valid rises 2 cycles after the 4th bit is captured.
- EXEC_M: a counter starts at 0 and increments each cycle.
  - dp_done=1: capture dp_result, set result_valid, go to DONE.
  - Counter reaches TIMEOUT-1 without dp_done: result=0, result_valid=1, timeout_err=1, go to DONE.
  - dp_done on that same last cycle wins; no error.
- DONE: result, result_valid and opcode are held; load edges are ignored and bits_loaded stays 4. dp_done in states other than EXEC_M is ignored.
- reset_instr=0 in any state, including mid-EXEC_M: return to LOAD next cycle.
  - Clears opcode, bits_loaded, result, result_valid, timeout_err and the counter; dp_start is forced 0.
  - A load edge in the same cycle as reset_instr=0 is discarded.
  - A dp_done that arrives after an abort is ignored.
- Load edges while reset_instr is held low are discarded.
- A load edge in ISSUE, EXEC_1 or EXEC_M is discarded and not queued.
- opcode 0000 is a valid opcode (XOR) and is treated as single-cycle.

Test Plan:
- Loader: reset_all, then 4 load edges with bits 0,0,0,1 (ADD 1000) and dp_result=38 -> bits_loaded 1..4, opcode=1000, one dp_start pulse, result=38, result_valid=1, busy low in DONE.
- Multi-cycle op: load MUL 1011, bench asserts dp_done 10 cycles after dp_start with dp_result=357 -> busy high for 10 cycles, result=357, timeout_err=0.
- Timeout: load DIV 1100 and never assert dp_done -> after TIMEOUT=64 cycles in EXEC_M: timeout_err=1, result=0, result_valid=1.
- Abort mid-op: load MOD 1010, pull reset_instr low at EXEC_M cycle 3, then dp_done arrives -> LOAD with all outputs 0; the late dp_done has no effect.
- Held level and ignored edges: hold instr_load_en high for 1000 cycles -> bits_loaded increments once. In DONE, 3 more load edges -> opcode and result unchanged.
- Reset priority and partial clear: reset_all=1 with reset_instr=0 -> full reset. After 2 bits loaded, reset_instr pulse low -> bits_loaded=0, opcode=0, and the next 4 edges load cleanly.
